// File: rtl/snake_input_core.sv
// Snake front end: game-tick divider, LFSR-based food/normal generator and
// synchronized push-button to non-reversing one-hot direction decoder.
module snake_input_core #(
    parameter int unsigned DIVISOR = 2000000,
    parameter int unsigned X_CELLS = 80,
    parameter int unsigned Y_CELLS = 60,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       right,
    input  logic       left,
    input  logic       down,
    output logic       out_clk,
    output logic       tick,
    output logic [6:0] randX,
    output logic [6:0] randY,
    output logic [2:0] normal,
    output logic [3:0] direction
);

    localparam int unsigned CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIVISOR - 1);

    typedef enum logic [3:0] {
        DIR_UP    = 4'b0001,
        DIR_RIGHT = 4'b0010,
        DIR_LEFT  = 4'b0100,
        DIR_DOWN  = 4'b1000
    } dir_t;

    function automatic logic [6:0] x_of(input logic [15:0] l);
        return 7'(32'(l[6:0]) % X_CELLS);
    endfunction

    function automatic logic [6:0] y_of(input logic [15:0] l);
        return 7'(32'(l[14:8]) % Y_CELLS);
    endfunction

    function automatic logic [2:0] n_of(input logic [15:0] l);
        return {l[15], l[10], l[5]};
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [15:0]      lfsr;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic             wrap_c;
    logic             rise_c;
    logic             feedback_c;
    logic [3:0]       opposite_c;
    dir_t             state;
    dir_t             next_state;

    assign wrap_c     = (cnt == CNT_MAX);
    assign rise_c     = wrap_c & ~out_clk;
    assign feedback_c = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Clock divider; tick marks the cycle in which out_clk first reads high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            out_clk <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt  <= wrap_c ? '0 : cnt + CNT_W'(1);
            tick <= rise_c;
            if (wrap_c) begin
                out_clk <= ~out_clk;
            end
        end
    end

    // LFSR advances on each game tick; outputs are re-registered from it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr   <= SEED;
            randX  <= x_of(SEED);
            randY  <= y_of(SEED);
            normal <= n_of(SEED);
        end else begin
            if (rise_c) begin
                lfsr <= {lfsr[14:0], feedback_c};
            end
            randX  <= x_of(lfsr);
            randY  <= y_of(lfsr);
            normal <= n_of(lfsr);
        end
    end

    // Two-flop synchronizer, bit order {down, left, right, up}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {down, left, right, up};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DIR_DOWN;
        end else begin
            state <= next_state;
        end
    end

    // With this encoding the reverse direction is the bit-reversed code
    always_comb begin
        next_state = state;
        opposite_c = {state[0], state[1], state[2], state[3]};
        if ($onehot(sync2) && (sync2 != opposite_c)) begin
            next_state = dir_t'(sync2);
        end
    end

    assign direction = state;

endmodule

// File: tb/tb_snake_input_core.sv
// Directed bench for snake_input_core: divider timing, LFSR outputs,
// direction decoding and asynchronous mid-run reset.
module tb_snake_input_core;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       up, right, left, down;
    logic       out_clk, tick;
    logic [6:0] randX, randY;
    logic [2:0] normal;
    logic [3:0] direction;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model;
    bit found;

    snake_input_core #(
        .DIVISOR(D), .X_CELLS(80), .Y_CELLS(60), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .up(up), .right(right), .left(left), .down(down),
        .out_clk(out_clk), .tick(tick), .randX(randX), .randY(randY),
        .normal(normal), .direction(direction)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // b = {down, left, right, up}
    task automatic set_btn(input logic [3:0] b);
        {down, left, right, up} = b;
    endtask

    task automatic press(input string tag, input logic [3:0] b, input logic [3:0] exp);
        @(negedge clk);
        set_btn(b);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(tag, 32'(direction), 32'(exp));
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    initial begin
        rst = 1'b0;
        set_btn(4'b0000);
        #12;
        check("rst_out_clk", 32'(out_clk), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_dir", 32'(direction), 32'h8);
        check("rst_randX", 32'(randX), 17);
        check("rst_randY", 32'(randY), 44);
        check("rst_normal", 32'(normal), 7);

        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("out_clk_e%0d", k), 32'(out_clk), 32'(((k / 4) % 2) == 1));
            check($sformatf("tick_e%0d", k), 32'(tick), 32'((k % 8) == 4));
            if (k == 4) check("randX_pre", 32'(randX), 17);
            if (k == 5) begin
                check("randX_t1", 32'(randX), 67);
                check("randY_t1", 32'(randY), 29);
                check("normal_t1", 32'(normal), 0);
            end
        end

        check("dir_idle", 32'(direction), 32'h8);
        press("up_vs_down", 4'b0001, 4'b1000);
        press("down_same", 4'b1000, 4'b1000);
        @(negedge clk);
        set_btn(4'b0100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("left_early", 32'(direction), 32'h8);
        @(posedge clk);
        @(negedge clk);
        check("left_turn", 32'(direction), 32'h4);
        press("right_vs_left", 4'b0010, 4'b0100);
        press("left_same", 4'b0100, 4'b0100);
        press("up_turn", 4'b0001, 4'b0001);
        press("none_hold", 4'b0000, 4'b0001);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_clk) found = 1'b1;
        end
        check("wait_out_clk_high", 32'(found), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_clk", 32'(out_clk), 0);
        check("mid_rst_tick", 32'(tick), 0);
        check("mid_rst_dir", 32'(direction), 32'h8);
        check("mid_rst_randX", 32'(randX), 17);
        check("mid_rst_randY", 32'(randY), 44);
        check("mid_rst_normal", 32'(normal), 7);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("restart_out_clk_e%0d", k), 32'(out_clk), 32'(k == 4));
        end

        press("up_left_combo", 4'b0101, 4'b1000);
        press("combo_release", 4'b0000, 4'b1000);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model = 16'hACE1;
        for (int t = 0; t < 1000; t++) begin
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (tick) found = 1'b1;
            end
            check("tick_seen", 32'(found), 1);
            if (!found) break;
            model = step(model);
            @(negedge clk);
            check("model_randX", 32'(randX), 32'(model[6:0]) % 80);
            check("model_randY", 32'(randY), 32'(model[14:8]) % 60);
            check("model_normal", 32'(normal), 32'({model[15], model[10], model[5]}));
            check("range_randX", 32'(randX < 7'd80), 1);
            check("range_randY", 32'(randY < 7'd60), 1);
        end
        check("lfsr_nonzero", 32'(model != 16'h0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
